// File: rtl/batch_pkg.sv
`default_nettype none
// batch_pkg: width helpers, bank type and bank-role offsets shared by the batch sequencer.
package batch_pkg;

  localparam int BANK_W_MAX = 8;
  typedef logic [BANK_W_MAX-1:0] bank_t;

  // Bank role offsets relative to the write bank: lookahead reads one bank back.
  localparam bank_t LH = bank_t'(1);

  function automatic bank_t calc_off(input int n_bank);
    return bank_t'(n_bank - 1);
  endfunction

  function automatic int cw_of(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int bw_of(input int n_bank);
    return $clog2(n_bank);
  endfunction

  function automatic int vw_of(input int depth, input int n_bank, input int lat);
    return $clog2(n_bank * depth + lat + 3);
  endfunction

  function automatic bank_t bank_sub(input bank_t cyc, input bank_t off, input int n_bank);
    return (cyc - off) & bank_t'(n_bank - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/batch_delay_line.sv
`default_nettype none
// batch_delay_line: LEN-stage shift register advancing on en_i, synchronous active-low clear.
module batch_delay_line
  import batch_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int LEN   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] stage_q [LEN];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < LEN; i++) stage_q[i] <= '0;
    end else if (en_i) begin
      stage_q[0] <= data_i;
      for (int i = 1; i < LEN; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign data_o = stage_q[LEN-1];

endmodule
`default_nettype wire

// File: rtl/batch_sequencer.sv
`default_nettype none
// batch_sequencer: address, recursion-strobe and valid-flag sequencer for the batch filter.
// Define BATCH_DEPTH_RUNTIME_EN to add the depth_cfg_i port (batch length latched at reset/wrap).
module batch_sequencer
  import batch_pkg::*;
#(
  parameter  int DEPTH  = 15,
  parameter  int N_BANK = 4,
  parameter  int LAT    = 2,
  localparam int CW     = cw_of(DEPTH),
  localparam int BW     = bw_of(N_BANK),
  localparam int VW     = vw_of(DEPTH, N_BANK, LAT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
`ifdef BATCH_DEPTH_RUNTIME_EN
  input  logic [CW-1:0]    depth_cfg_i,
`endif
  output logic [CW+BW-1:0] addr_in_o,
  output logic [CW+BW-1:0] addr_lh_o,
  output logic [CW+BW-1:0] addr_fr_o,
  output logic [CW+BW-1:0] addr_br_o,
  output logic [CW:0]      res_addr_in_o,
  output logic [CW:0]      res_addr_out_f_o,
  output logic [CW:0]      res_addr_out_b_o,
  output logic             rec_rst_n_o,
  output logic             compute_valid_o,
  output logic             out_valid_o
);

  localparam int DW = CW + 1;
  localparam int AW = CW + BW;

  logic [DW-1:0] depth_w;
  logic          cnt_restart_w;
  logic          last_w;
  logic [CW-1:0] fwd_q, fwd_d, rev_w;
  logic [BW-1:0] cycle_q, cycle_d, lh_bank_w, calc_bank_w;
  logic [VW-1:0] cnt_q, cnt_d, vd_w, cv_th_w;
  logic          cv_q, cv_d, ov_q, ov_d;
  logic [AW-1:0] addr_in_q, addr_lh_q, addr_fr_q, addr_br_q;

`ifdef BATCH_DEPTH_RUNTIME_EN
  logic [DW-1:0] depth_q, cfg_w;

  always_comb begin
    cfg_w = {1'b0, depth_cfg_i};
    if (cfg_w < DW'(2))          cfg_w = DW'(2);
    else if (cfg_w > DW'(DEPTH)) cfg_w = DW'(DEPTH);
  end

  always_ff @(posedge clk) begin
    if (!rst)                depth_q <= cfg_w;
    else if (en_i && last_w) depth_q <= cfg_w;
  end

  assign depth_w       = depth_q;
  assign cnt_restart_w = en_i && last_w && (cfg_w != depth_q);
`else
  assign depth_w       = DW'(DEPTH);
  assign cnt_restart_w = 1'b0;
`endif

  assign last_w      = ({1'b0, fwd_q} == depth_w - DW'(1));
  assign rev_w       = CW'(depth_w - DW'(1) - {1'b0, fwd_q});
  assign lh_bank_w   = BW'(bank_sub(bank_t'(cycle_q), LH, N_BANK));
  assign calc_bank_w = BW'(bank_sub(bank_t'(cycle_q), calc_off(N_BANK), N_BANK));
  assign vd_w        = VW'(N_BANK * int'(depth_w) + LAT + 2);
  assign cv_th_w     = VW'((N_BANK - 1) * int'(depth_w) + LAT);

  always_comb begin
    fwd_d   = last_w ? '0 : fwd_q + CW'(1);
    cycle_d = last_w ? cycle_q + BW'(1) : cycle_q;
    if (cnt_restart_w)     cnt_d = '0;
    else if (cnt_q >= vd_w) cnt_d = cnt_q;
    else                   cnt_d = cnt_q + VW'(1);
    cv_d = cv_q | (cnt_d == cv_th_w);
    ov_d = (cnt_d == vd_w);
  end

  // Addresses capture the pre-advance counters of the step being taken.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fwd_q     <= '0;
      cycle_q   <= '0;
      cnt_q     <= '0;
      cv_q      <= 1'b0;
      ov_q      <= 1'b0;
      addr_in_q <= '0;
      addr_lh_q <= '0;
      addr_fr_q <= '0;
      addr_br_q <= '0;
    end else if (en_i) begin
      fwd_q     <= fwd_d;
      cycle_q   <= cycle_d;
      cnt_q     <= cnt_d;
      cv_q      <= cv_d;
      ov_q      <= ov_d;
      addr_in_q <= {fwd_q, cycle_q};
      addr_lh_q <= {rev_w, lh_bank_w};
      addr_fr_q <= {fwd_q, calc_bank_w};
      addr_br_q <= {rev_w, calc_bank_w};
    end
  end

  logic [CW-1:0] fwd_dl_w, fwd_e_w, rev_dl_w;
  logic          cycn_dl_w, cyc_e_w, rec_dl_w;

  batch_delay_line #(.WIDTH(CW), .LEN(LAT + 2)) u_fwd_d (
    .clk(clk), .rst(rst), .en_i(en_i), .data_i(fwd_q), .data_o(fwd_dl_w));
  batch_delay_line #(.WIDTH(CW), .LEN(1)) u_fwd_e (
    .clk(clk), .rst(rst), .en_i(en_i), .data_i(fwd_dl_w), .data_o(fwd_e_w));
  batch_delay_line #(.WIDTH(CW), .LEN(LAT + 2)) u_rev_d (
    .clk(clk), .rst(rst), .en_i(en_i), .data_i(rev_w), .data_o(rev_dl_w));

  // Bank bit travels inverted so the result-read addresses clear to zero.
  batch_delay_line #(.WIDTH(1), .LEN(LAT + 2)) u_cycn_d (
    .clk(clk), .rst(rst), .en_i(en_i), .data_i(~cycle_q[0]), .data_o(cycn_dl_w));
  batch_delay_line #(.WIDTH(1), .LEN(1)) u_cyc_e (
    .clk(clk), .rst(rst), .en_i(en_i), .data_i(~cycn_dl_w), .data_o(cyc_e_w));
  batch_delay_line #(.WIDTH(1), .LEN(LAT + 2)) u_rec_d (
    .clk(clk), .rst(rst), .en_i(en_i), .data_i(last_w), .data_o(rec_dl_w));

  assign addr_in_o        = addr_in_q;
  assign addr_lh_o        = addr_lh_q;
  assign addr_fr_o        = addr_fr_q;
  assign addr_br_o        = addr_br_q;
  assign res_addr_in_o    = {fwd_e_w, cyc_e_w};
  assign res_addr_out_f_o = {fwd_dl_w, cycn_dl_w};
  assign res_addr_out_b_o = {rev_dl_w, cycn_dl_w};
  assign rec_rst_n_o      = ~rec_dl_w;
  assign compute_valid_o  = cv_q;
  assign out_valid_o      = ov_q;

endmodule
`default_nettype wire
